freq_lock_checker: RTL
======================

# freq_lock_checker

Per-channel frequency qualifier that sits directly downstream of the frequency monitor in the `ref_clk` domain. It consumes the packed 20-bit KHz tallies once per measurement window and compares each channel against a programmed window, expected value ± tolerance. Each channel gets a hysteresis lock state machine, and status bits feed the control/status register file: lock, sticky loss-of-lock alarm, interrupt and overrun.

## Interface
- `NUM_SIGNALS`, 4: number of monitored channels (1..16).
- `EXPECT_KHZ`, 20'd156250: nominal frequency in KHz, common to all channels.
- `TOL_KHZ`, 20'd100: allowed deviation in KHz; the window is inclusive.
- `LOCK_COUNT`, 3: consecutive in-range measurements needed to lock (1..15).
- `UNLOCK_COUNT`, 2: consecutive out-of-range measurements needed to unlock (1..15).

- `ref_clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `khz_counters` in 20*NUM_SIGNALS: channel i occupies bits [20i+19:20i]; held stable between `meas_valid` pulses.
- `meas_valid` in 1: one-cycle pulse that marks a new set of tallies.
- `alarm_clr` in NUM_SIGNALS: write-1-to-clear pulses for `alarm`.
- `locked` out NUM_SIGNALS: channel qualified in range.
- `alarm` out NUM_SIGNALS: sticky, set on a LOCKED→UNLOCKED transition.
- `dead` out NUM_SIGNALS: last measurement was 0 KHz. Active only with the macro described under Configuration.
- `irq` out 1: registered OR of `alarm`.
- `busy` out 1: scan in progress.
- `scan_done` out 1: one-cycle pulse when the scan completes.
- `overrun` out 1: sticky; a `meas_valid` arrived while `busy`. Cleared only by reset.

## Operation
- Top FSM has two states:
  - IDLE → SCAN on `meas_valid`. All tallies are copied into a shadow register and the channel index is set to 0.
  - SCAN evaluates one channel per cycle, channel index 0..NUM_SIGNALS-1.
  - SCAN → IDLE after the last channel is evaluated.
- Window bounds are computed at 21 bits so they never wrap:
  - lo = max(EXPECT_KHZ − TOL_KHZ, 0).
  - hi = min(EXPECT_KHZ + TOL_KHZ, 20'hFFFFF).
  - in_range = lo ≤ value ≤ hi.
- Each channel has its own FSM with states UNLOCKED and LOCKED, plus 4-bit `good_cnt` and `bad_cnt` counters.
  - UNLOCKED, in range: `good_cnt`++ and `bad_cnt`=0. When `good_cnt` reaches LOCK_COUNT, go to LOCKED and clear `good_cnt`.
  - UNLOCKED, out of range: `good_cnt`=0.
  - LOCKED, out of range: `bad_cnt`++ and `good_cnt`=0. When `bad_cnt` reaches UNLOCK_COUNT, go to UNLOCKED, clear `bad_cnt` and set `alarm[i]`.
  - LOCKED, in range: `bad_cnt`=0.
  - Counters saturate; they never wrap.
- `alarm[i]`: if a set and an `alarm_clr[i]` occur in the same cycle, the set wins. `alarm_clr` is honoured in any FSM state.
- `meas_valid` while `busy` is dropped and sets `overrun`. The shadow register and the scan are unaffected.
- `meas_valid` in the same cycle that `scan_done` is high is accepted, because the FSM is already in IDLE.

## Timing
- Reset values: all outputs 0, both FSM levels in IDLE/UNLOCKED, all counters 0.
- `rst_n` asserted mid-scan aborts the scan immediately with no `scan_done`. The state is exactly the reset state.
- Latency: `meas_valid` sampled at edge E0 loads the shadow and raises `busy`.
  - Channel k's `locked`, `alarm` and `dead` update at edge E0+k+1.
  - `scan_done` is high for the cycle after edge E0+NUM_SIGNALS.
  - `busy` falls at that same edge.
- `irq` follows `alarm` by one cycle.
- Minimum spacing between `meas_valid` pulses: NUM_SIGNALS+1 cycles.

## Configuration
- `FREQ_LOCK_CHECKER_DEAD_DETECT_EN` defined:
  - A value of 0 sets `dead[i]`. `dead[i]` clears on the next non-zero measurement.
  - A LOCKED channel that reads 0 goes to UNLOCKED immediately, ignoring UNLOCK_COUNT, and sets `alarm[i]`.
- Macro undefined:
  - `dead` is tied to 0.
  - A value of 0 is treated as an ordinary out-of-range measurement.

## Test plan
All scenarios use default parameters.
1. Reset: hold `rst_n`=0, drive `meas_valid` → all outputs stay 0. Release reset → no `scan_done` until the first `meas_valid`.
2. Lock: ch0=156250, ch1=156351. Three `meas_valid` pulses spaced 10 cycles apart → `locked`=4'b0001 at edge E0+1 of the third scan. `scan_done` appears 5 cycles after each pulse.
3. Window bounds: 156150 and 156350 lock after 3 scans; 156149 and 156351 never lock. With EXPECT_KHZ=50 and TOL_KHZ=100, a value of 0 is in range, showing the lower bound clamps at 0 instead of wrapping.
4. Hysteresis and alarm, on a locked ch2:
   - Sequence out, in, out → stays locked.
   - Then out, out → `locked[2]`=0, `alarm[2]`=1, `irq`=1 one cycle later.
   - `alarm_clr[2]` in the set cycle → `alarm[2]` stays 1. A later clear → 0.
5. Overrun: `meas_valid` at E0+2 → ignored, `overrun`=1, and scan results match the first capture.
6. With the macro defined, a locked ch3 reads 0 → `locked[3]`=0, `alarm[3]`=1 and `dead[3]`=1 after one scan. Without the macro, it unlocks only after two zero scans and `dead` stays 0.

Source files
------------

// File: rtl/freq_lock_checker.sv
// Per-channel frequency qualifier: scans one channel per cycle through a hysteresis lock FSM.
// Optional zero-frequency detection is enabled by defining FREQ_LOCK_CHECKER_DEAD_DETECT_EN.
module freq_lock_checker #(
  parameter int          NUM_SIGNALS  = 4,
  parameter logic [19:0] EXPECT_KHZ   = 20'd156250,
  parameter logic [19:0] TOL_KHZ      = 20'd100,
  parameter int          LOCK_COUNT   = 3,
  parameter int          UNLOCK_COUNT = 2
) (
  input  logic                        ref_clk,
  input  logic                        rst_n,
  input  logic [20*NUM_SIGNALS-1:0]   khz_counters,
  input  logic                        meas_valid,
  input  logic [NUM_SIGNALS-1:0]      alarm_clr,
  output logic [NUM_SIGNALS-1:0]      locked,
  output logic [NUM_SIGNALS-1:0]      alarm,
  output logic [NUM_SIGNALS-1:0]      dead,
  output logic                        irq,
  output logic                        busy,
  output logic                        scan_done,
  output logic                        overrun
);

  localparam int          IW         = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SIGNALS - 1);
  localparam logic [3:0]  LOCK_CNT   = 4'(LOCK_COUNT);
  localparam logic [3:0]  UNLOCK_CNT = 4'(UNLOCK_COUNT);

  // Bounds are held at 21 bits so the window clamps instead of wrapping.
  localparam logic [20:0] SUM_KHZ = {1'b0, EXPECT_KHZ} + {1'b0, TOL_KHZ};
  localparam logic [20:0] LO_KHZ  = (EXPECT_KHZ >= TOL_KHZ) ? ({1'b0, EXPECT_KHZ} - {1'b0, TOL_KHZ}) : 21'd0;
  localparam logic [20:0] HI_KHZ  = (SUM_KHZ > 21'h0FFFFF) ? 21'h0FFFFF : SUM_KHZ;

  typedef enum logic {S_IDLE, S_SCAN} topState_e;
  typedef enum logic {S_UNLOCKED, S_LOCKED} chanState_e;

  topState_e               state_q;
  logic [IW-1:0]           idx_q;
  logic [19:0]             shadow_q   [NUM_SIGNALS];
  chanState_e              chState_q  [NUM_SIGNALS];
  logic [3:0]              goodCnt_q  [NUM_SIGNALS];
  logic [3:0]              badCnt_q   [NUM_SIGNALS];
  logic [NUM_SIGNALS-1:0]  alarm_q;
  logic                    irq_q;
  logic                    busy_q;
  logic                    scanDone_q;
  logic                    overrun_q;

  logic [19:0]             curVal;
  logic                    inRange;
  logic                    forceUnlock;
  logic [3:0]              goodInc;
  logic [3:0]              badInc;
  chanState_e              chState_d;
  logic [3:0]              goodCnt_d;
  logic [3:0]              badCnt_d;
  logic                    setAlarm;
  logic [NUM_SIGNALS-1:0]  alarm_d;

`ifdef FREQ_LOCK_CHECKER_DEAD_DETECT_EN
  logic                    isZero;
  logic [NUM_SIGNALS-1:0]  dead_q;
  assign isZero      = (curVal == 20'd0);
  assign forceUnlock = isZero && (chState_q[idx_q] == S_LOCKED);
  assign dead        = dead_q;
`else
  assign forceUnlock = 1'b0;
  assign dead        = '0;
`endif

  always_comb begin
    curVal    = shadow_q[idx_q];
    inRange   = ({1'b0, curVal} >= LO_KHZ) && ({1'b0, curVal} <= HI_KHZ);
    goodInc   = (goodCnt_q[idx_q] == 4'hF) ? 4'hF : goodCnt_q[idx_q] + 4'd1;
    badInc    = (badCnt_q[idx_q] == 4'hF) ? 4'hF : badCnt_q[idx_q] + 4'd1;
    chState_d = chState_q[idx_q];
    goodCnt_d = goodCnt_q[idx_q];
    badCnt_d  = badCnt_q[idx_q];
    setAlarm  = 1'b0;
    if (forceUnlock) begin
      chState_d = S_UNLOCKED;
      goodCnt_d = 4'd0;
      badCnt_d  = 4'd0;
      setAlarm  = 1'b1;
    end else if (chState_q[idx_q] == S_UNLOCKED) begin
      if (inRange) begin
        badCnt_d = 4'd0;
        if (goodInc >= LOCK_CNT) begin
          chState_d = S_LOCKED;
          goodCnt_d = 4'd0;
        end else begin
          goodCnt_d = goodInc;
        end
      end else begin
        goodCnt_d = 4'd0;
      end
    end else begin
      if (!inRange) begin
        goodCnt_d = 4'd0;
        if (badInc >= UNLOCK_CNT) begin
          chState_d = S_UNLOCKED;
          badCnt_d  = 4'd0;
          setAlarm  = 1'b1;
        end else begin
          badCnt_d = badInc;
        end
      end else begin
        badCnt_d = 4'd0;
      end
    end
    // A set from the channel being scanned takes priority over a same-cycle clear.
    alarm_d = alarm_q & ~alarm_clr;
    if ((state_q == S_SCAN) && setAlarm) begin
      alarm_d[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      alarm_q    <= '0;
      irq_q      <= 1'b0;
      busy_q     <= 1'b0;
      scanDone_q <= 1'b0;
      overrun_q  <= 1'b0;
      for (int i = 0; i < NUM_SIGNALS; i++) begin
        shadow_q[i]  <= 20'd0;
        chState_q[i] <= S_UNLOCKED;
        goodCnt_q[i] <= 4'd0;
        badCnt_q[i]  <= 4'd0;
      end
`ifdef FREQ_LOCK_CHECKER_DEAD_DETECT_EN
      dead_q     <= '0;
`endif
    end else begin
      scanDone_q <= 1'b0;
      alarm_q    <= alarm_d;
      irq_q      <= |alarm_q;
      if (meas_valid && (state_q == S_SCAN)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (meas_valid) begin
            for (int i = 0; i < NUM_SIGNALS; i++) begin
              shadow_q[i] <= khz_counters[20*i +: 20];
            end
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          chState_q[idx_q] <= chState_d;
          goodCnt_q[idx_q] <= goodCnt_d;
          badCnt_q[idx_q]  <= badCnt_d;
`ifdef FREQ_LOCK_CHECKER_DEAD_DETECT_EN
          dead_q[idx_q]    <= isZero;
`endif
          if (idx_q == LAST_IDX) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            scanDone_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SIGNALS; i++) begin
      locked[i] = (chState_q[i] == S_LOCKED);
    end
  end

  assign alarm     = alarm_q;
  assign irq       = irq_q;
  assign busy      = busy_q;
  assign scan_done = scanDone_q;
  assign overrun   = overrun_q;

endmodule
